// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
// Optional build macro used by clk_div_ctrl: CLK_DIV_CTRL_PERIOD_CNT_EN.
package clk_div_pkg;

  // Controller states: IDLE (stopped), RUN (dividing), STOP (finishing last period).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Smallest divide ratio that still gives a real divided clock.
  localparam logic [31:0] DIV_MIN = 32'd2;

  // Ratios 0 and 1 cannot produce a 50% duty output and are rejected.
  function automatic logic div_legal(input logic [31:0] val);
    return (val >= DIV_MIN);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: cycle counter, posedge/negedge duty flops and output OR.
// The ratio register lives here so the counter compare and the duty threshold
// always see the same value; it only changes when the controller pulses load,
// which happens at a period boundary or while stopped.
module clk_div_core #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] div_n,
  input  logic             run,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             count_end,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_clk
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] div_q;
  logic             act_q;
  logic             hi_p;
  logic             hi_n;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] cnt_inc;

  // Ratio is always >= 2, so div_q - 1 never underflows and cnt_q + 1 stays
  // below div_q whenever it is used.
  assign half      = div_q >> 1;
  assign last      = div_q - WIDTH'(1);
  assign cnt_inc   = cnt_q + WIDTH'(1);
  assign count_end = act_q && (cnt_q == last);

  // Counter and high-phase flop; every period (including the first after IDLE) starts at count 0 with hi_p set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      div_q <= WIDTH'(DEFAULT_DIV);
      act_q <= 1'b0;
      hi_p  <= 1'b0;
    end else begin
      if (load) div_q <= div_n;
      if (!run) begin
        act_q <= 1'b0;
        cnt_q <= '0;
        hi_p  <= 1'b0;
      end else if (!act_q || count_end) begin
        act_q <= 1'b1;
        cnt_q <= '0;
        hi_p  <= 1'b1;
      end else begin
        cnt_q <= cnt_inc;
        hi_p  <= (cnt_inc < half);
      end
    end
  end

  // Half-cycle extension for odd ratios; held low for even ratios so the OR passes hi_p alone.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_n <= 1'b0;
    end else begin
      hi_n <= hi_p & div_q[0];
    end
  end

  assign div_clk = hi_p | hi_n;
  assign count   = cnt_q;
  assign div_cur = div_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable integer clock divider controller (top).
// Sequences enable/disable and ratio changes onto output-period boundaries so
// o_div_clk never glitches. Build macro CLK_DIV_CTRL_PERIOD_CNT_EN adds the
// saturating o_period_cnt output.
//
// Ratio-change handshake: the requester raises i_div_req with i_div_val and
// holds both until o_div_ack. A request is accepted on a posedge where
// i_div_req = 1, o_busy = 0 and o_div_ack = 0. Legal values set o_busy and are
// applied at the next wrap (or the next edge when IDLE); the edge that applies
// them raises o_div_ack for one cycle and drops o_busy. Illegal values raise
// o_div_ack and o_div_err together on the acceptance edge and never set o_busy.
// The requester drops i_div_req after seeing o_div_ack.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic             i_div_req,
  input  logic [WIDTH-1:0] i_div_val,
  output logic             o_div_ack,
  output logic             o_div_err,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_div_cur,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end,
  output logic             o_div_clk,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  output logic [15:0]      o_period_cnt,
`endif
  output state_t           o_state
);

  if ((DEFAULT_DIV < 2) || (DEFAULT_DIV > (1 << WIDTH) - 1)) begin : g_bad_default
    $error("clk_div_ctrl: DEFAULT_DIV out of range 2..2^WIDTH-1");
  end

  state_t           state_q;
  state_t           state_nxt;
  logic             pend_q;
  logic [WIDTH-1:0] req_q;
  logic             ack_q;
  logic             err_q;
  logic             accept;
  logic             load;
  logic             run;
  logic             core_end;

  assign accept = i_div_req && !pend_q && !ack_q;
  assign load   = pend_q && ((state_q == ST_IDLE) || core_end);
  assign run    = (state_nxt != ST_IDLE);

  // Next-state decode: enable changes only stop the divider at a wrap.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (i_en) state_nxt = ST_RUN;
      ST_RUN:  if (!i_en) state_nxt = core_end ? ST_IDLE : ST_STOP;
      ST_STOP: begin
        if (i_en)          state_nxt = ST_RUN;
        else if (core_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state plus request latch and registered ack/err pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      if (load) begin
        pend_q <= 1'b0;
        ack_q  <= 1'b1;
      end else if (accept) begin
        if (div_legal(32'(i_div_val))) begin
          pend_q <= 1'b1;
          req_q  <= i_div_val;
        end else begin
          ack_q <= 1'b1;
          err_q <= 1'b1;
        end
      end
    end
  end

  clk_div_core #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk       (clk),
    .resetn    (resetn),
    .div_n     (req_q),
    .run       (run),
    .load      (load),
    .count     (o_count),
    .count_end (core_end),
    .div_cur   (o_div_cur),
    .div_clk   (o_div_clk)
  );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] per_q;

  // Count completed output periods since the last ratio change, saturating.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      per_q <= '0;
    end else if (load) begin
      per_q <= '0;
    end else if (core_end && (per_q != 16'hFFFF)) begin
      per_q <= per_q + 16'd1;
    end
  end

  assign o_period_cnt = per_q;
`endif

  assign o_div_ack   = ack_q;
  assign o_div_err   = err_q;
  assign o_busy      = pend_q;
  assign o_count_end = core_end;
  assign o_state     = state_q;

endmodule
